// File: rtl/aes_enc_block_fetch.sv
// Avalon-MM read master: fetches 4-word blocks from on-chip plaintext memory and streams
// them as 128-bit blocks to the AES core. Define AES_FETCH_BSWAP_EN to byte-reverse each word.
module aes_enc_block_fetch #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned CNT_W  = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_blocks,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic [127:0]      blk_data,
    output logic              blk_valid,
    input  logic              blk_ready
);

    typedef enum logic [2:0] {StIdle, StIssue, StDrain, StPresent, StFin} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [1:0]          idx_q;
    logic                rd_pend_q;
    logic [1:0]          rd_lane_q;
    logic [3:0][31:0]    lane_q;
    logic [31:0]         word_in;

    always_comb begin
`ifdef AES_FETCH_BSWAP_EN
        word_in = {mem_readdata[7:0], mem_readdata[15:8], mem_readdata[23:16],
                   mem_readdata[31:24]};
`else
        word_in = mem_readdata;
`endif
    end

    always_comb begin
        state_d        = state_q;
        busy           = 1'b0;
        done           = 1'b0;
        mem_chipselect = 1'b0;
        blk_valid      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = (num_blocks != '0) ? StIssue : StFin;
            end
            StIssue: begin
                busy           = 1'b1;
                mem_chipselect = 1'b1;
                if (idx_q == 2'd3) state_d = StDrain;
            end
            StDrain: begin
                busy    = 1'b1;
                state_d = StPresent;
            end
            StPresent: begin
                busy      = 1'b1;
                blk_valid = 1'b1;
                if (blk_ready) state_d = (cnt_q == CNT_W'(1)) ? StFin : StIssue;
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem_address    = ptr_q;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    // Lane 0 holds the lowest-address word and lands in the top bits.
    assign blk_data       = {lane_q[0], lane_q[1], lane_q[2], lane_q[3]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            rd_pend_q <= 1'b0;
            rd_lane_q <= 2'd0;
            lane_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && start && num_blocks != '0) begin
                ptr_q <= base_addr;
                cnt_q <= num_blocks;
                idx_q <= 2'd0;
            end
            if (state_q == StIssue) begin
                ptr_q <= ptr_q + ADDR_W'(1);
                idx_q <= idx_q + 2'd1;
            end
            // Read data returns one cycle after issue; remember which lane it belongs to.
            rd_pend_q <= (state_q == StIssue);
            rd_lane_q <= idx_q;
            if (rd_pend_q) lane_q[rd_lane_q] <= word_in;
            if (state_q == StPresent && blk_ready) cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_aes_enc_block_fetch.sv
// Scoreboard bench for aes_enc_block_fetch: expected addresses and blocks are queued when a
// transfer is started and popped as the DUT issues reads and hands off blocks.
module tb_aes_enc_block_fetch;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [12:0]  base_addr = '0;
    logic [11:0]  num_blocks = '0;
    logic         busy, done;
    logic [12:0]  mem_address;
    logic         mem_chipselect, mem_write, mem_clken;
    logic [3:0]   mem_byteenable;
    logic [31:0]  mem_readdata;
    logic [127:0] blk_data;
    logic         blk_valid;
    logic         blk_ready = 1'b0;

    int total = 0;
    int bad = 0;

    logic [31:0]  mem [0:8191];
    logic [31:0]  mem_rd = '0;
    logic [127:0] exp_blk_q[$];
    logic [12:0]  exp_addr_q[$];

    aes_enc_block_fetch dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .num_blocks     (num_blocks),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .blk_data       (blk_data),
        .blk_valid      (blk_valid),
        .blk_ready      (blk_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_chipselect) mem_rd <= mem[mem_address];
    assign mem_readdata = mem_rd;

    function automatic logic [31:0] conv(input logic [31:0] w);
`ifdef AES_FETCH_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic push_expect(input logic [12:0] base, input logic [11:0] num);
        logic [12:0]  a;
        logic [127:0] blk;
        for (int b = 0; b < int'(num); b++) begin
            blk = '0;
            for (int w = 0; w < 4; w++) begin
                a = base + 13'(b * 4 + w);
                exp_addr_q.push_back(a);
                blk = {blk[95:0], conv(mem[a])};
            end
            exp_blk_q.push_back(blk);
        end
    endtask

    task automatic run_xfer(input logic [12:0] base, input logic [11:0] num, input int stall,
                            input bit poke, output int first_valid, output int done_cyc);
        int          budget, dones, wait_cnt, post;
        logic [12:0] a;
        logic [127:0] eb;
        push_expect(base, num);
        @(negedge clk);
        base_addr = base; num_blocks = num; start = 1'b1; blk_ready = 1'b0;
        budget = int'(num) * (6 + stall) + 20;
        first_valid = 0; done_cyc = 0; dones = 0; wait_cnt = 0; post = 0;
        for (int cyc = 1; cyc <= budget && post < 4; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0; base_addr = 13'h0ABC; num_blocks = 12'd7;
            end
            if (poke) start = (cyc == 2);
            if (num != 0 && cyc == 1) begin
                total++;
                if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b want 1", busy); end
            end
            if (num == 0) begin
                total++;
                if (busy !== 1'b0 || mem_chipselect !== 1'b0) begin
                    bad++;
                    $display("FAIL zero_len_idle: busy=%b cs=%b want 0 0", busy, mem_chipselect);
                end
            end
            if (mem_chipselect) begin
                total++;
                if (exp_addr_q.size() == 0) begin
                    bad++; $display("FAIL extra_read: got addr %h want no read", mem_address);
                end else begin
                    a = exp_addr_q.pop_front();
                    if (mem_address !== a) begin
                        bad++; $display("FAIL read_addr: got %h want %h", mem_address, a);
                    end
                end
            end
            if (blk_valid) begin
                if (first_valid == 0) first_valid = cyc;
                total++;
                if (mem_chipselect !== 1'b0) begin
                    bad++; $display("FAIL read_while_valid: got cs=%b want 0", mem_chipselect);
                end
                total++;
                if (exp_blk_q.size() == 0) begin
                    bad++; $display("FAIL extra_block: got %h want none", blk_data);
                end else if (blk_data !== exp_blk_q[0]) begin
                    bad++; $display("FAIL blk_data: got %h want %h", blk_data, exp_blk_q[0]);
                end
            end
            if (done) begin
                dones++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (dones > 0) post++;
            if (blk_valid && wait_cnt < stall) begin
                blk_ready = 1'b0; wait_cnt++;
            end else begin
                blk_ready = 1'b1;
            end
            if (blk_valid && blk_ready) begin
                if (exp_blk_q.size() != 0) eb = exp_blk_q.pop_front();
                wait_cnt = 0;
            end
        end
        start = 1'b0;
        blk_ready = 1'b0;
        total++;
        if (dones != 1) begin bad++; $display("FAIL done_count: got %0d want 1", dones); end
        total++;
        if (exp_addr_q.size() != 0 || exp_blk_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got addr=%0d blk=%0d pending want 0 0",
                     exp_addr_q.size(), exp_blk_q.size());
        end
        exp_addr_q.delete();
        exp_blk_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, mem_address, mem_chipselect, blk_valid, blk_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b addr=%h cs=%b v=%b data=%h want 0",
                     busy, done, mem_address, mem_chipselect, blk_valid, blk_data);
        end
        total++;
        if (mem_write !== 1'b0 || mem_byteenable !== 4'hF || mem_clken !== 1'b1) begin
            bad++;
            $display("FAIL tied_outputs: got wr=%b be=%h ck=%b want 0 f 1",
                     mem_write, mem_byteenable, mem_clken);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        int fv, dc;
        run_xfer(13'h0010, 12'd1, 0, 1'b0, fv, dc);
        total++;
        if (fv != 6) begin bad++; $display("FAIL single_latency: got cycle %0d want 6", fv); end
        total++;
        if (dc != 7) begin bad++; $display("FAIL single_done: got cycle %0d want 7", dc); end
    endtask

    task automatic test_wrap();
        int fv, dc;
        run_xfer(13'h1FFE, 12'd1, 0, 1'b0, fv, dc);
    endtask

    task automatic test_stall();
        int fv, dc;
        run_xfer(13'h0200, 12'd3, 10, 1'b0, fv, dc);
        total++;
        if (dc != 49) begin bad++; $display("FAIL stall_done: got cycle %0d want 49", dc); end
    endtask

    task automatic test_zero_len();
        int fv, dc;
        run_xfer(13'h0040, 12'd0, 0, 1'b0, fv, dc);
        total++;
        if (dc != 1 || fv != 0) begin
            bad++; $display("FAIL zero_len: got done=%0d valid=%0d want 1 0", dc, fv);
        end
    endtask

    task automatic test_reset_mid();
        int fv, dc;
        @(negedge clk);
        base_addr = 13'h0100; num_blocks = 12'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if ({busy, done, mem_address, mem_chipselect, blk_valid, blk_data} !== '0) begin
            bad++;
            $display("FAIL reset_mid: got busy=%b done=%b addr=%h cs=%b v=%b want 0",
                     busy, done, mem_address, mem_chipselect, blk_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) reset_n = 1'b1;
            total++;
            if (done !== 1'b0 || blk_data !== '0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_quiet: got done=%b busy=%b data=%h want 0", done, busy, blk_data);
            end
        end
        run_xfer(13'h0000, 12'd1, 0, 1'b0, fv, dc);
        total++;
        if (fv != 6) begin bad++; $display("FAIL restart_latency: got cycle %0d want 6", fv); end
    endtask

    task automatic test_bswap_and_busy_start();
        int fv, dc;
        mem[0] = 32'h11223344;
        run_xfer(13'h0000, 12'd1, 0, 1'b1, fv, dc);
        total++;
        if (dc != 7) begin bad++; $display("FAIL busy_start_done: got cycle %0d want 7", dc); end
    endtask

    task automatic test_back_to_back();
        int fv, dc;
        run_xfer(13'h1FFA, 12'd2, 0, 1'b0, fv, dc);
        total++;
        if (dc != 13) begin bad++; $display("FAIL b2b_done: got cycle %0d want 13", dc); end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 32'(i);
        test_reset();
        test_single();
        test_wrap();
        test_stall();
        test_zero_len();
        test_reset_mid();
        test_bswap_and_busy_start();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
